data_mem_stage: RTL and testbench

Memory-access pipeline stage with the MEM/WB pipeline register built in. It takes execute-stage results, performs byte/half/word loads and stores against a private data memory with a configurable number of wait states, and stalls upstream while an access is in flight. Its registered outputs (ALUResultOut, DataMemOut, MemToReg, RegWrite, writeReg) drive the write-back output selector directly.

---
 rtl/data_mem_stage_pkg.sv | 25 ++
 rtl/data_mem_stage_array.sv | 27 ++
 rtl/data_mem_stage.sv | 167 ++++++++++++++++
 tb/tb_data_mem_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states, wait-state limit.
// Pure definitions; no logic, no timing.
package data_mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WAIT_STATES_MAX = 7;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // Reserved size 2'b11 is treated as a word, so it needs word alignment.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~lane[0];
            default: return (lane == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/data_mem_stage_array.sv
// DEPTH x 32 data memory: asynchronous read, synchronous byte-enabled write.
// Shared read/write address; contents are not reset.
module data_mem_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_stage.sv
// MEM stage with built-in MEM/WB register: byte/half/word loads and stores, WAIT_STATES extra cycles per access.
// Non-memory ops land in MEM/WB next cycle; memory ops hold stall high for WAIT_STATES cycles first.
module data_mem_stage
    import data_mem_stage_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    input  logic [31:0] ALUResult,
    input  logic [31:0] writeDataIn,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  memSize,
    input  logic        loadUnsigned,
    input  logic        MemToRegIn,
    input  logic        RegWriteIn,
    input  logic [4:0]  writeRegIn,
    output logic        stall,
    output logic        outValid,
    output logic [31:0] ALUResultOut,
    output logic [31:0] DataMemOut,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic [4:0]  writeReg,
    output logic        misalign
);

    localparam int WS = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
    localparam logic [2:0] WS_M1 = (WS > 0) ? 3'(WS - 1) : 3'd0;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        capture;

    logic [1:0]        lane;
    logic [ADDR_W-1:0] word_idx;
    logic              mem_req, aligned, mem_op, misaligned, is_store, is_load;
    logic [3:0]        be;
    logic [31:0]       wdata, rdata, load_val;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;

    logic        outValid_q, MemToReg_q, RegWrite_q, misalign_q;
    logic [31:0] ALUResult_q, DataMem_q;
    logic [4:0]  writeReg_q;

    assign lane       = ALUResult[1:0];
    assign word_idx   = ALUResult[ADDR_W+1:2];
    assign mem_req    = inValid & (MemRead | MemWrite);
    assign aligned    = is_aligned(memSize, lane);
    assign mem_op     = mem_req & aligned;
    assign misaligned = mem_req & ~aligned;
    // Read+write together is a store; only a pure read returns load data.
    assign is_store   = mem_op & MemWrite;
    assign is_load    = mem_op & MemRead & ~MemWrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && (WS != 0)) begin
                    stall   = 1'b1;
                    cnt_d   = WS_M1;
                    state_d = ST_WAIT;
                end else begin
                    capture = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 3'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign lane_byte = rdata[{lane, 3'b000} +: 8];
    assign lane_half = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be       = 4'b1111;
        wdata    = writeDataIn;
        load_val = rdata;
        case (memSize)
            SZ_BYTE: begin
                be       = 4'b0001 << lane;
                wdata    = {4{writeDataIn[7:0]}};
                load_val = {{24{~loadUnsigned & lane_byte[7]}}, lane_byte};
            end
            SZ_HALF: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{writeDataIn[15:0]}};
                load_val = {{16{~loadUnsigned & lane_half[15]}}, lane_half};
            end
            default: ;
        endcase
    end

    data_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .addr_i  (word_idx),
        .we_i    (capture & is_store & ~reset),
        .be_i    (be),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid_q  <= 1'b0;
            ALUResult_q <= 32'd0;
            DataMem_q   <= 32'd0;
            MemToReg_q  <= 1'b0;
            RegWrite_q  <= 1'b0;
            writeReg_q  <= 5'd0;
            misalign_q  <= 1'b0;
        end else if (capture) begin
            outValid_q  <= inValid;
            ALUResult_q <= ALUResult;
            DataMem_q   <= is_load ? load_val : 32'd0;
            MemToReg_q  <= inValid & MemToRegIn;
            RegWrite_q  <= inValid & RegWriteIn & ~misaligned;
            writeReg_q  <= writeRegIn;
            misalign_q  <= misaligned;
        end else begin
            // Stall cycles send bubbles to WB.
            outValid_q <= 1'b0;
            MemToReg_q <= 1'b0;
            RegWrite_q <= 1'b0;
            misalign_q <= 1'b0;
        end
    end

    assign outValid     = outValid_q;
    assign ALUResultOut = ALUResult_q;
    assign DataMemOut   = DataMem_q;
    assign MemToReg     = MemToReg_q;
    assign RegWrite     = RegWrite_q;
    assign writeReg     = writeReg_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboard bench for data_mem_stage with WAIT_STATES=2, DEPTH=256.
module tb_data_mem_stage;
    import data_mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] writeDataIn = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  memSize = SZ_WORD;
    logic        loadUnsigned = 1'b0;
    logic        MemToRegIn = 1'b0;
    logic        RegWriteIn = 1'b0;
    logic [4:0]  writeRegIn = '0;
    logic        stall, outValid, MemToReg, RegWrite, misalign;
    logic [31:0] ALUResultOut, DataMemOut;
    logic [4:0]  writeReg;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] dmem;
        logic        m2r;
        logic        rw;
        logic [4:0]  wreg;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    data_mem_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .ALUResult(ALUResult),
        .writeDataIn(writeDataIn), .MemRead(MemRead), .MemWrite(MemWrite),
        .memSize(memSize), .loadUnsigned(loadUnsigned), .MemToRegIn(MemToRegIn),
        .RegWriteIn(RegWriteIn), .writeRegIn(writeRegIn), .stall(stall),
        .outValid(outValid), .ALUResultOut(ALUResultOut), .DataMemOut(DataMemOut),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .writeReg(writeReg), .misalign(misalign)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && outValid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected alu=%h dmem=%h", ALUResultOut, DataMemOut);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({ALUResultOut, DataMemOut, MemToReg, RegWrite, writeReg, misalign} !==
                    {e.alu, e.dmem, e.m2r, e.rw, e.wreg, e.mis}) begin
                    bad++;
                    $display("FAIL wb_entry got alu=%h dmem=%h m2r=%b rw=%b wreg=%0d mis=%b want alu=%h dmem=%h m2r=%b rw=%b wreg=%0d mis=%b",
                             ALUResultOut, DataMemOut, MemToReg, RegWrite, writeReg, misalign,
                             e.alu, e.dmem, e.m2r, e.rw, e.wreg, e.mis);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the capture edge.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdat, input logic m2r,
                         input logic rwin, input logic [4:0] wreg, input logic [31:0] exp_dmem,
                         input logic exp_rw, input logic exp_mis, output int stalls);
        exp_t e;
        inValid = 1'b1; MemRead = rd; MemWrite = wr; memSize = sz; loadUnsigned = uns;
        ALUResult = addr; writeDataIn = wdat; MemToRegIn = m2r; RegWriteIn = rwin; writeRegIn = wreg;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (stall !== 1'b1) break;
            stalls++;
            @(posedge clk); #1;
        end
        e.alu = addr; e.dmem = exp_dmem; e.m2r = m2r; e.rw = exp_rw; e.wreg = wreg; e.mis = exp_mis;
        sb.push_back(e);
        @(posedge clk); #1;
        inValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain pending=%0d want=0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({outValid, ALUResultOut, DataMemOut, MemToReg, RegWrite, writeReg, misalign} !== 72'd0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b alu=%h dmem=%h m2r=%b rw=%b wreg=%0d mis=%b want all 0",
                     outValid, ALUResultOut, DataMemOut, MemToReg, RegWrite, writeReg, misalign);
        end
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        int st;
        issue(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h7, 32'h0, 1'b0, 1'b1, 5'd5, 32'h0, 1'b1, 1'b0, st);
        total++;
        if (outValid !== 1'b1) begin bad++; $display("FAIL alu_latency outValid=%b want=1", outValid); end
        total++;
        if (st !== 0) begin bad++; $display("FAIL alu_stall got=%0d want=0", st); end
        drain("alu");
    endtask

    task automatic test_store_load();
        int st1, st2;
        issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, st1);
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 1'b1, 1'b0, st2);
        total++;
        if (st1 !== 2) begin bad++; $display("FAIL sw_stall got=%0d want=2", st1); end
        total++;
        if (st2 !== 2) begin bad++; $display("FAIL lw_stall got=%0d want=2", st2); end
        drain("store_load");
    endtask

    task automatic test_lanes();
        int st;
        issue(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 5'd9, 32'hFFFFFFDE, 1'b1, 1'b0, st);
        issue(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 1'b1, 1'b1, 5'd10, 32'h000000DE, 1'b1, 1'b0, st);
        issue(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 5'd11, 32'hFFFFDEAD, 1'b1, 1'b0, st);
        issue(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 1'b1, 1'b1, 5'd12, 32'h000000BE, 1'b1, 1'b0, st);
        drain("lanes");
    endtask

    task automatic test_misalign();
        int st1, st2;
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0, 1'b1, 1'b1, 5'd3, 32'h0, 1'b0, 1'b1, st1);
        issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, st2);
        total++;
        if (st1 !== 0) begin bad++; $display("FAIL mis_load_stall got=%0d want=0", st1); end
        total++;
        if (st2 !== 0) begin bad++; $display("FAIL mis_store_stall got=%0d want=0", st2); end
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd4, 32'hDEADBEEF, 1'b1, 1'b0, st1);
        drain("misalign");
    endtask

    task automatic test_wrap();
        int st;
        issue(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h410, 32'h123456AA, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, st);
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd6, 32'hDEADBEAA, 1'b1, 1'b0, st);
        issue(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 1'b1, 1'b1, 5'd7, 32'h0000BEAA, 1'b1, 1'b0, st);
        drain("wrap");
    endtask

    task automatic test_both_rw();
        int st;
        issue(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h11112222, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, st);
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 5'd13, 32'h11112222, 1'b1, 1'b0, st);
        drain("both_rw");
    endtask

    task automatic test_reset_wait();
        int st;
        issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, st);
        drain("pre_reset");
        inValid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; memSize = SZ_WORD;
        ALUResult = 32'h20; writeDataIn = 32'h12345678; RegWriteIn = 1'b0; MemToRegIn = 1'b0;
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL rst_wait_stall got=%b want=1", stall); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; inValid = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        total++;
        if ({stall, outValid, ALUResultOut, DataMemOut, MemToReg, RegWrite, writeReg, misalign} !== 73'd0) begin
            bad++;
            $display("FAIL rst_wait_outputs got stall=%b v=%b alu=%h dmem=%h rw=%b want all 0",
                     stall, outValid, ALUResultOut, DataMemOut, RegWrite);
        end
        @(posedge clk); #1;
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd14, 32'hCAFEF00D, 1'b1, 1'b0, st);
        drain("rst_wait");
    endtask

    task automatic test_back_to_back();
        int st;
        logic [31:0] a, d;
        for (int i = 0; i < 4; i++) begin
            a = {22'd0, 8'($urandom_range(64, 255)), 2'b00};
            d = $urandom;
            issue(1'b0, 1'b1, SZ_WORD, 1'b0, a, d, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, st);
            issue(1'b1, 1'b0, SZ_WORD, 1'b0, a, 32'h0, 1'b1, 1'b1, 5'(i + 16), d, 1'b1, 1'b0, st);
            total++;
            if (st !== 2) begin bad++; $display("FAIL b2b_stall iter=%0d got=%0d want=2", i, st); end
        end
        drain("b2b");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_store_load();
        test_lanes();
        test_misalign();
        test_wrap();
        test_both_rw();
        test_reset_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
